// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one memory port with alternating priority
// on contention and a bounded wait that completes with err on timeout.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int WEN_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ready,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_valid,
  input  logic [WEN_W-1:0] d_wen,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ready,
  output logic [WIDTH-1:0] d_rdata,
  output logic             err,
  output logic             mem_valid,
  output logic [WEN_W-1:0] mem_wen,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    RECOVER
  } state_t;

  state_t state, state_d;

  logic             last_d, last_d_d;
  logic [7:0]       cnt, cnt_d;
  logic             grant_i, grant_d;
  logic             busy, tmo, done;
  logic             mem_valid_d;
  logic [WEN_W-1:0] mem_wen_d;
  logic [WIDTH-1:0] mem_addr_d, mem_wdata_d;
  logic             i_ready_d, d_ready_d, err_d;
  logic [WIDTH-1:0] i_rdata_d, d_rdata_d;

  // On contention the side that did not win last time goes first.
  assign grant_i = i_valid && (!d_valid || last_d);
  assign grant_d = d_valid && !grant_i;
  assign busy    = (state == I_BUSY) || (state == D_BUSY);
  assign tmo     = (cnt == 8'(TIMEOUT - 1));
  assign done    = busy && (mem_ready || tmo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_d    <= 1'b1;
      cnt       <= '0;
      mem_valid <= 1'b0;
      mem_wen   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_d;
      last_d    <= last_d_d;
      cnt       <= cnt_d;
      mem_valid <= mem_valid_d;
      mem_wen   <= mem_wen_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      i_ready   <= i_ready_d;
      d_ready   <= d_ready_d;
      err       <= err_d;
      i_rdata   <= i_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (grant_i)      state_d = I_BUSY;
        else if (grant_d) state_d = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (done) state_d = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d_d    = last_d;
    cnt_d       = cnt;
    mem_valid_d = mem_valid;
    mem_wen_d   = mem_wen;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = i_rdata;
    d_rdata_d   = d_rdata;
    unique case (state)
      IDLE: begin
        if (grant_i || grant_d) begin
          mem_valid_d = 1'b1;
          cnt_d       = '0;
          last_d_d    = grant_d;
          mem_addr_d  = grant_i ? i_addr : d_addr;
          mem_wen_d   = grant_i ? '0 : d_wen;
          mem_wdata_d = grant_i ? '0 : d_wdata;
        end
      end
      I_BUSY, D_BUSY: begin
        if (done) begin
          mem_valid_d = 1'b0;
          mem_wen_d   = '0;
          err_d       = !mem_ready;
          if (state == I_BUSY) begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline model, directed cases
// with literal expectations, then randomized traffic with resets.
module tb_mem_arbiter;
  localparam int W  = 32;
  localparam int WW = 4;
  localparam int T  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_ready, d_valid, d_ready, err;
  logic [W-1:0]  i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [WW-1:0] d_wen, mem_wen;
  logic          mem_valid, mem_ready;
  logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.WIDTH(W), .WEN_W(WW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_wen(d_wen), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .err(err),
    .mem_valid(mem_valid), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // requesters
  logic          ip, dp;
  logic [W-1:0]  ia, da, dwd;
  logic [WW-1:0] dw;
  int            igap, dgap;
  // current transaction timeline: grant in g, busy g+1..g+k
  logic          act, tside, terr, last_d;
  int            cyc, g, k, dly;
  logic [W-1:0]  trd, taddr, twd;
  logic [WW-1:0] twen;
  logic [W-1:0]  ihold, dhold;
  logic          e_mv, e_ir, e_dr, e_err;
  // knobs
  logic          auto_req, use_frd;
  int            max_gap, force_d, spur_mode;
  logic [W-1:0]  frd;

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic reset_model();
    act = 1'b0; last_d = 1'b1;
    ihold = '0; dhold = '0;
    ip = 1'b0; dp = 1'b0; igap = 0; dgap = 0;
    e_mv = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_err = 1'b0;
    i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic finish_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", W'(mem_valid), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wen", W'(mem_wen), 0);
    chk("rst_ready", W'({i_ready, d_ready, err}), 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    rst = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    reset_model();
    finish_reset();
  endtask

  task automatic check_cycle();
    chk("mem_valid", W'(mem_valid), W'(e_mv));
    chk("i_ready", W'(i_ready), W'(e_ir));
    chk("d_ready", W'(d_ready), W'(e_dr));
    chk("err", W'(err), W'(e_err));
    chk("i_rdata", i_rdata, ihold);
    chk("d_rdata", d_rdata, dhold);
    if (e_mv) begin
      chk("mem_addr", mem_addr, taddr);
      chk("mem_wen", W'(mem_wen), W'(twen));
      chk("mem_wdata", mem_wdata, twd);
    end
  endtask

  task automatic step();
    logic busy;
    @(posedge clk);
    #1;
    cyc++;
    busy  = act && cyc >= g + 1 && cyc <= g + k;
    e_mv  = busy;
    e_ir  = act && !tside && cyc == g + k + 1;
    e_dr  = act && tside && cyc == g + k + 1;
    e_err = act && terr && cyc == g + k + 1;
    if (e_ir) ihold = terr ? '0 : trd;
    if (e_dr) dhold = terr ? '0 : trd;
    if (act && cyc == g + k + 2) begin
      act = 1'b0;
      if (tside) begin
        dp = 1'b0; dgap = int'($urandom_range(0, max_gap));
      end else begin
        ip = 1'b0; igap = int'($urandom_range(0, max_gap));
      end
    end
    if (auto_req && !ip) begin
      if (igap > 0) igap--;
      else begin ip = 1'b1; ia = $urandom & 32'hffff_fffc; end
    end
    if (auto_req && !dp) begin
      if (dgap > 0) dgap--;
      else begin
        dp = 1'b1; da = $urandom & 32'hffff_fffc;
        dw = WW'($urandom); dwd = $urandom;
      end
    end
    if (!act && (ip || dp)) begin
      tside  = !(ip && (!dp || last_d));
      last_d = tside;
      act    = 1'b1;
      g      = cyc;
      if (force_d >= 0) dly = force_d;
      else if ($urandom_range(0, 1) == 0) dly = 1;
      else dly = int'($urandom_range(1, T + 1));
      terr  = (dly + 1 > T);
      k     = terr ? T : dly + 1;
      trd   = use_frd ? frd : $urandom;
      taddr = tside ? da : ia;
      twen  = tside ? dw : '0;
      twd   = tside ? dwd : '0;
    end
    i_valid = ip; i_addr = ia;
    d_valid = dp; d_addr = da; d_wen = dw; d_wdata = dwd;
    if (busy) begin
      mem_ready = (cyc >= g + 1 + dly);
      mem_rdata = trd;
    end else begin
      mem_ready = (spur_mode == 2) ||
                  (spur_mode == 1 && $urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
    end
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    int cnt;
    logic [15:0] im, dm;
    rst = 1'b0; cyc = 0; g = 0; k = 0; dly = 0;
    tside = 1'b0; terr = 1'b0; trd = '0;
    taddr = '0; twd = '0; twen = '0;
    ia = '0; da = '0; dwd = '0; dw = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wen = '0; mem_rdata = '0;
    auto_req = 1'b0; use_frd = 1'b0; max_gap = 0;
    force_d = -1; spur_mode = 0; frd = '0;
    do_reset();

    // fetch after reset, memory answers next cycle
    ip = 1'b1; ia = 32'h10; use_frd = 1'b1; frd = 32'h0001_8eb7; force_d = 1;
    step();
    chk("f_mv_n0", W'(mem_valid), 0);
    step();
    chk("f_mv_n1", W'(mem_valid), 1);
    chk("f_addr_n1", mem_addr, 32'h10);
    step();
    step();
    chk("f_ready_n3", W'(i_ready), 1);
    chk("f_rdata_n3", i_rdata, 32'h0001_8eb7);
    chk("f_err_n3", W'(err), 0);
    step();
    chk("f_ready_n4", W'(i_ready), 0);

    // data write held until memory answers
    dp = 1'b1; dw = 4'hf; da = 32'h20; dwd = 32'hdead_beef;
    frd = 32'h0bad_f00d; force_d = 3; cnt = 0;
    for (int s = 0; s < 8; s++) begin
      step();
      if (s >= 1 && s <= 4) begin
        chk("w_wen", W'(mem_wen), 32'hf);
        chk("w_addr", mem_addr, 32'h20);
        chk("w_wdata", mem_wdata, 32'hdead_beef);
      end
      cnt += int'(d_ready);
    end
    chk("w_pulses", W'(cnt), 1);

    // ready on the last allowed busy cycle is not a timeout
    dp = 1'b1; dw = 4'h0; da = 32'h24; frd = 32'h55aa; force_d = T - 1;
    for (int s = 0; s < T + 3; s++) begin
      step();
      if (s == T + 1) begin
        chk("edge_ready", W'(d_ready), 1);
        chk("edge_err", W'(err), 0);
        chk("edge_rdata", d_rdata, 32'h55aa);
      end
    end

    // no memory answer: timeout, spurious ready in recover ignored
    dp = 1'b1; da = 32'h28; force_d = T + 3; spur_mode = 2;
    for (int s = 0; s < T + 4; s++) begin
      step();
      if (s == T) chk("to_mv_last", W'(mem_valid), 1);
      if (s == T + 1) begin
        chk("to_ready", W'(d_ready), 1);
        chk("to_err", W'(err), 1);
        chk("to_rdata", d_rdata, 0);
        chk("to_mv", W'(mem_valid), 0);
      end
    end

    // spurious ready while idle
    cnt = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      cnt += int'(i_ready) + int'(d_ready);
    end
    chk("spur_ready", W'(cnt), 0);
    spur_mode = 0;

    // both held from reset: I,D,I,D every 4 cycles
    do_reset();
    auto_req = 1'b1; max_gap = 0; force_d = 1; use_frd = 1'b0;
    im = '0; dm = '0;
    for (int s = 0; s < 16; s++) begin
      step();
      im[s] = i_ready;
      dm[s] = d_ready;
    end
    chk("alt_i", W'(im), 32'h0808);
    chk("alt_d", W'(dm), 32'h8080);

    // reset mid fetch: async clear, then fetch wins first grant
    auto_req = 1'b0;
    do_reset();
    ip = 1'b1; ia = 32'h40; force_d = T + 3;
    step(); step(); step();
    #2;
    rst = 1'b0;
    reset_model();
    #1;
    chk("mid_rst_mv", W'(mem_valid), 0);
    chk("mid_rst_ir", W'(i_ready), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_ir2", W'(i_ready), 0);
    finish_reset();
    ip = 1'b1; ia = 32'h44; dp = 1'b1; da = 32'h80; dw = '0;
    force_d = 1;
    step(); step();
    chk("post_rst_first", mem_addr, 32'h44);
    for (int s = 0; s < 8; s++) step();

    // randomized traffic with occasional asynchronous resets
    auto_req = 1'b1; max_gap = 3; force_d = -1; spur_mode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 800; s++) step();
      #($urandom_range(1, 3));
      rst = 1'b0;
      reset_model();
      finish_reset();
    end
    for (int s = 0; s < 400; s++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
